alu_div32: RTL
==============

# alu_div32

Sequential 32-bit integer divider that complements the combinational multiplier path in the ALU. It produces quotient and remainder for unsigned or signed operands using a radix-2 restoring algorithm, one quotient bit per clock. Operation uses a start/busy/done handshake. Status flags follow the ALU flag conventions so the result can feed the same flag logic as the other ALU sub-units.

## Interface
- WIDTH, 32, operand/result width; only 32 is verified.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only in IDLE.
- op1  in  4  operation select; 4'b0000 unsigned divide, 4'b0001 signed divide; only op1[0] is decoded.
- in0  in  32  dividend; sampled only on the accepting edge.
- in1  in  32  divisor; sampled only on the accepting edge.
- busy  out  1  high from the accepting edge until the done edge.
- done  out  1  one-cycle pulse; results are valid in the same cycle.
- quot  out  32  quotient; held until the next done.
- rem  out  32  remainder; held until the next done.
- zero  out  1  quot == 0.
- N  out  1  quot[31].
- overflow  out  1  signed INT_MIN / -1.
- div_zero  out  1  divisor was 0.
- All outputs reset to 0.

## Operation
- States are IDLE, CALC, FIX.
- **IDLE:** start=1 captures operands.
  - Signed mode: the magnitudes |in0| and |in1| are latched, plus sign_q = in0[31]^in1[31] and sign_r = in0[31].
  - Then rem_acc = 0, cnt = 0, busy = 1.
  - If in1 == 0, go to FIX directly. Otherwise go to CALC.
- **CALC:** each edge:
  - Shift {rem_acc, dividend} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - cnt++. After the 32nd step, go to FIX.
- **FIX:** one edge.
  - Apply signs: quotient negated if sign_q, remainder negated if sign_r.
  - Write quot, rem, zero, N, overflow and div_zero.
  - Pulse done, drop busy, return to IDLE.
- **Divide by zero:**
  - quot = 32'hFFFFFFFF, rem = in0 (original, unmodified), div_zero = 1, overflow = 0.
  - Applies in both modes.
- **Signed overflow (in0 = 32'h80000000, in1 = 32'hFFFFFFFF, signed):**
  - quot = 32'h80000000, rem = 0, overflow = 1.
  - Takes the full 33-cycle path; the natural magnitude arithmetic yields this result.
- Remainder sign follows the dividend; |rem| < |in1|.
- Unsigned mode: sign_q = sign_r = 0, overflow always 0.
- Flags other than those written at FIX keep their previous values.

## Timing
- Accepting edge is E0.
- Normal latency: CALC occupies edges E1..E32, FIX is E33. done and the results are visible after E33 (33 cycles). busy is high after E0 through E33.
- Divide by zero: FIX at E1, done after E1.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted at the next edge because the state is IDLE. Throughput is one operation per 34 cycles.
- start while busy is ignored, with no queuing.
- Operand changes after E0 have no effect.
- rst_n low at any time, including mid-CALC, clears all state and outputs immediately. No done is issued for the aborted operation.

## Structure
- **Shared package alu_pkg:**
  - op1 codes DIV_U = 4'b0000, DIV_S = 4'b0001.
  - State enum IDLE/CALC/FIX.
  - Constant for WIDTH.
  - Constants DIV0_QUOT = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- **Sub-module div_step:** combinational one-bit restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once and reused each CALC cycle.
- The FSM, counter, operand registers and sign fix-up live in alu_div32.

## Test plan
- Unsigned 100 / 7 -> quot=14, rem=2, zero=0, done exactly 33 cycles after accept, busy high throughout.
- Signed -7 / 2 (32'hFFFFFFF9, 2) -> quot=32'hFFFFFFFD, rem=32'hFFFFFFFF, N=1; and 7 / -2 -> quot=32'hFFFFFFFD, rem=1.
- Unsigned 5 / 0 -> quot=32'hFFFFFFFF, rem=5, div_zero=1, done 1 cycle after accept.
- Signed 32'h80000000 / 32'hFFFFFFFF -> quot=32'h80000000, rem=0, overflow=1; unsigned 32'hFFFFFFFF / 1 -> quot=32'hFFFFFFFF, overflow=0.
- Unsigned 3 / 10 -> quot=0, rem=3, zero=1.
- Second start at cycle 10 of an operation is ignored, and the first result is unchanged. Then start 50 / 5 in the done cycle -> accepted next edge, quot=10.
- rst_n pulsed low at CALC cycle 15 -> all outputs 0, no done. A new operation after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: opcodes, FSM state and constants
// used by the sequential divider path.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] DIV_U = 4'b0000;
  localparam logic [3:0] DIV_S = 4'b0001;

  localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [WIDTH-1:0] INT_MIN   = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic logic [WIDTH-1:0] abs_v(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/alu_div32_step.sv
// One radix-2 restoring division step: shift in a dividend
// bit, trial-subtract the divisor, keep or restore.
import alu_pkg::*;

module div_step (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             unused_d;

  assign sh   = {rem_i, bit_i};
  assign diff = {1'b0, sh} - {2'b00, dvs_i};
  assign q_o  = ~diff[WIDTH+1];

  // rem_i < dvs_i keeps the kept difference inside WIDTH bits
  assign rem_o    = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign unused_d = diff[WIDTH];

endmodule

// File: rtl/alu_div32.sv
// Sequential 32-bit divider: start/busy/done handshake,
// one quotient bit per cycle, sign fix-up in FIX.
import alu_pkg::*;

module alu_div32 (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             N,
  output logic             overflow,
  output logic             div_zero
);

  state_e           state_q;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] racc_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sgq_q;
  logic             sgr_q;
  logic             ovf_q;

  logic             is_s;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] rem_d;
  logic             unused_c;

  assign is_s     = (op1 & 4'b0001) == DIV_S;
  assign unused_c = ^DIV_U;

  div_step u_step (
    .rem_i (racc_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quot_d = sgq_q ? -dvd_q : dvd_q;
  assign rem_d  = sgr_q ? -racc_q : racc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      racc_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgq_q    <= 1'b0;
      sgr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      zero     <= 1'b0;
      N        <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            racc_q <= '0;
            cnt_q  <= '0;
            busy   <= 1'b1;
            sgq_q  <= is_s & (in0[31] ^ in1[31]);
            sgr_q  <= is_s & in0[31];
            ovf_q  <= is_s && in0 == INT_MIN
                      && in1 == '1;
            dvs_q  <= is_s ? abs_v(in1) : in1;
            // raw dividend kept for the div-by-zero remainder
            if (in1 == '0) begin
              dvd_q   <= in0;
              state_q <= FIX;
            end else begin
              dvd_q   <= is_s ? abs_v(in0) : in0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          racc_q <= step_rem;
          dvd_q  <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          if (dvs_q == '0) begin
            quot     <= DIV0_QUOT;
            rem      <= dvd_q;
            zero     <= 1'b0;
            N        <= DIV0_QUOT[WIDTH-1];
            overflow <= 1'b0;
            div_zero <= 1'b1;
          end else begin
            quot     <= quot_d;
            rem      <= rem_d;
            zero     <= quot_d == '0;
            N        <= quot_d[WIDTH-1];
            overflow <= ovf_q;
            div_zero <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
